// File: rtl/linreg_pkg.sv
// linreg_pkg: shared fixed-point defaults, FSM encoding and accumulator sizing
// for the linreg_predict inference block.
package linreg_pkg;

    localparam int          BITS_DEF  = 16;
    localparam int          FRAC_DEF  = 10;
    localparam logic [15:0] WINIT_DEF = 16'h0100;
    localparam logic [15:0] ONE_Q     = 16'h0400;

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } linreg_state_e;

    // Full product plus enough headroom that F+1 summed terms never wrap.
    function automatic int accWidth(input int bits, input int f);
        return 2 * bits + $clog2(f + 1);
    endfunction

endpackage

// File: rtl/linreg_mac.sv
// linreg_mac: signed x*w product, floored by FRAC bits, summed into a wide
// accumulator with synchronous clear (priority) and enable.
module linreg_mac
    import linreg_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int ACCW = 35
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [BITS-1:0] x_i,
    input  logic [BITS-1:0] w_i,
    output logic [ACCW-1:0] sum_o
);

    logic signed [2*BITS-1:0] xExt;
    logic signed [2*BITS-1:0] wExt;
    logic signed [2*BITS-1:0] prod;
    logic signed [2*BITS-1:0] prodShift;
    logic        [ACCW-1:0]   term;
    logic        [ACCW-1:0]   acc_q;
    logic        [ACCW-1:0]   acc_d;

    // Both operands widened first so the multiply yields the exact full product.
    assign xExt      = {{BITS{x_i[BITS-1]}}, x_i};
    assign wExt      = {{BITS{w_i[BITS-1]}}, w_i};
    assign prod      = xExt * wExt;
    assign prodShift = prod >>> FRAC;
    assign term      = {{(ACCW - 2*BITS){prodShift[2*BITS-1]}}, prodShift};
    assign sum_o     = acc_q + term;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/linreg_predict.sv
// linreg_predict: weight store, serial feature intake and prediction handshake.
// Optional LINREG_SAT_EN saturates the result to the BITS-bit range and flags ovf.
module linreg_predict
    import linreg_pkg::*;
#(
    parameter int              BITS  = BITS_DEF,
    parameter int              FRAC  = FRAC_DEF,
    parameter int              F     = 4,
    parameter logic [BITS-1:0] WINIT = BITS'(WINIT_DEF)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     w_wr_en,
    input  logic [$clog2(F+1)-1:0]   w_wr_addr,
    input  logic [BITS-1:0]          w_wr_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [BITS-1:0]          x_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [BITS-1:0]          y_data,
    output logic                     ovf
);

    localparam int            AW       = $clog2(F + 1);
    localparam int            ACCW     = accWidth(BITS, F);
    localparam logic [AW-1:0] LAST_IDX = AW'(F);

    logic [BITS-1:0] weight_q [0:F];
    logic [AW-1:0]   idx_q,    idx_d;
    linreg_state_e   state_q,  state_d;
    logic            yValid_q, yValid_d;
    logic [BITS-1:0] yData_q,  yData_d;
    logic            ovf_q,    ovf_d;

    logic            beat;
    logic            lastBeat;
    logic            yFire;
    logic [ACCW-1:0] sum;
    logic [BITS-1:0] narrowData;
    logic            narrowOvf;

    assign x_ready  = (state_q == ACC);
    assign beat     = x_valid && (state_q == ACC);
    assign lastBeat = beat && (idx_q == LAST_IDX);
    assign yFire    = yValid_q && y_ready;

    assign y_valid  = yValid_q;
    assign y_data   = yData_q;
    assign ovf      = ovf_q;

    // The MAC reads the weight before any same-cycle write lands, so a beat sees the old value.
    linreg_mac #(
        .BITS (BITS),
        .FRAC (FRAC),
        .ACCW (ACCW)
    ) uMac (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (lastBeat),
        .en_i  (beat),
        .x_i   (x_data),
        .w_i   (weight_q[idx_q]),
        .sum_o (sum)
    );

`ifdef LINREG_SAT_EN
    always_comb begin
        narrowData = sum[BITS-1:0];
        narrowOvf  = 1'b0;
        if (sum[ACCW-1] && !(&sum[ACCW-1:BITS-1])) begin
            narrowData = {1'b1, {(BITS-1){1'b0}}};
            narrowOvf  = 1'b1;
        end else if (!sum[ACCW-1] && (|sum[ACCW-1:BITS-1])) begin
            narrowData = {1'b0, {(BITS-1){1'b1}}};
            narrowOvf  = 1'b1;
        end
    end
`else
    logic unusedSumHi;
    assign unusedSumHi = ^sum[ACCW-1:BITS];
    assign narrowData  = sum[BITS-1:0];
    assign narrowOvf   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        yValid_d = yValid_q;
        yData_d  = yData_q;
        ovf_d    = ovf_q;
        case (state_q)
            ACC: begin
                if (lastBeat) begin
                    idx_d    = '0;
                    yData_d  = narrowData;
                    ovf_d    = narrowOvf;
                    yValid_d = 1'b1;
                    state_d  = OUT;
                end else if (beat) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                if (yFire) begin
                    yValid_d = 1'b0;
                    state_d  = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ACC;
            idx_q    <= '0;
            yValid_q <= 1'b0;
            yData_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            yValid_q <= yValid_d;
            yData_q  <= yData_d;
            ovf_q    <= ovf_d;
        end
    end

    // Out-of-range addresses are dropped so they can never alias a real weight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i <= F; i++) begin
                weight_q[i] <= WINIT;
            end
        end else if (w_wr_en && (int'(w_wr_addr) <= F)) begin
            weight_q[w_wr_addr] <= w_wr_data;
        end
    end

endmodule
